// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_pkg.sv
// Shared types and constants for the multi-channel set-latch bank.
// Holds the sequencer state encoding and the saturating counter helper.
package gf180mcu_fd_sc_mcu9t5v0__latsnq_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    FILT    = 2'd1,
    SET     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if.sv
// Channel bus of the set-latch bank: per-channel E/D in, Q out, plus
// the shared set request, notifier and the status flags.
interface gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if #(
  parameter int WIDTH = 4
) ();
  import gf180mcu_fd_sc_mcu9t5v0__latsnq_pkg::*;

  logic [WIDTH-1:0] E;
  logic [WIDTH-1:0] D;
  logic             SETN;
  logic             NOTIFIER;
  logic             VIOL_CLR;
  logic [WIDTH-1:0] Q;
  logic             SET_ACTIVE;
  logic             VIOL;

  modport master (
    output E, D, SETN, NOTIFIER, VIOL_CLR,
    input  Q, SET_ACTIVE, VIOL
  );

  modport slave (
    input  E, D, SETN, NOTIFIER, VIOL_CLR,
    output Q, SET_ACTIVE, VIOL
  );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_filt.sv
// Low-active deglitch counter: qualified is high on the cycle in which the
// SET_FILT-th consecutive low sample of level is being taken.
module gf180mcu_fd_sc_mcu9t5v0__sync_filt
  import gf180mcu_fd_sc_mcu9t5v0__latsnq_pkg::*;
#(
  parameter int SET_FILT = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic level,
  output logic qualified
);

  localparam logic [CNT_W:0] THRESH = (CNT_W + 1)'(SET_FILT);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W:0]   run_s;

  // cnt_r holds the number of earlier consecutive low samples.
  always_comb begin
    cnt_nxt_s = cnt_r;
    run_s     = {1'b0, cnt_r} + 9'd1;
    if (level) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      qualified = 1'b0;
    end else begin
      cnt_nxt_s = sat_inc(cnt_r);
      qualified = (run_s >= THRESH);
    end
  end

  // Low-run counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank.sv
// WIDTH-channel enable-gated storage bank sharing one filtered active-low set
// request with a release delay, plus a sticky notifier-violation flag.
module gf180mcu_fd_sc_mcu9t5v0__latsnq_bank
  import gf180mcu_fd_sc_mcu9t5v0__latsnq_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               SET_FILT  = 3,
  parameter int               REL_DLY   = 2,
  parameter logic [WIDTH-1:0] SET_VAL   = '1,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter bit               DATA_PRIO = 1'b0
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if.slave bus
);

  localparam int REL_LAST_I = (REL_DLY > 0) ? (REL_DLY - 1) : 0;
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_LAST_I);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] rcnt_r;
  logic [CNT_W-1:0] rcnt_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] load_s;
  logic             set_zone_s;
  logic             set_active_r;
  logic             viol_r;
  logic             viol_nxt_s;
  logic             hist_r;
  logic             edge_s;
  logic             qual_s;

  gf180mcu_fd_sc_mcu9t5v0__sync_filt #(
    .SET_FILT (SET_FILT)
  ) u_filt (
    .CLK       (CLK),
    .RST       (RST),
    .level     (bus.SETN),
    .qualified (qual_s)
  );

  // Sequencer next state and release counter.
  always_comb begin
    state_nxt_s = state_r;
    rcnt_nxt_s  = rcnt_r;
    case (state_r)
      NORMAL: begin
        if (!bus.SETN) begin
          if (qual_s) begin
            state_nxt_s = SET;
          end else begin
            state_nxt_s = FILT;
          end
        end else begin
          state_nxt_s = NORMAL;
        end
      end
      FILT: begin
        if (bus.SETN) begin
          state_nxt_s = NORMAL;
        end else if (qual_s) begin
          state_nxt_s = SET;
        end else begin
          state_nxt_s = FILT;
        end
      end
      SET: begin
        if (bus.SETN) begin
          rcnt_nxt_s = {CNT_W{1'b0}};
          if (REL_DLY == 0) begin
            state_nxt_s = NORMAL;
          end else begin
            state_nxt_s = RELEASE;
          end
        end else begin
          state_nxt_s = SET;
        end
      end
      RELEASE: begin
        // A new low request re-enters SET directly, without refiltering.
        if (!bus.SETN) begin
          state_nxt_s = SET;
          rcnt_nxt_s  = {CNT_W{1'b0}};
        end else if (rcnt_r == REL_LAST) begin
          state_nxt_s = NORMAL;
          rcnt_nxt_s  = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = RELEASE;
          rcnt_nxt_s  = sat_inc(rcnt_r);
        end
      end
      default: begin
        state_nxt_s = NORMAL;
        rcnt_nxt_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Q follows the state being entered, so Q and SET_ACTIVE change together.
  always_comb begin
    set_zone_s = (state_nxt_s == SET) || (state_nxt_s == RELEASE);
    load_s     = (bus.E & bus.D) | (~bus.E & q_r);
    if (set_zone_s) begin
      if (DATA_PRIO) begin
        q_nxt_s = (bus.E & bus.D) | (~bus.E & SET_VAL);
      end else begin
        q_nxt_s = SET_VAL;
      end
    end else begin
      q_nxt_s = load_s;
    end
  end

  // Sticky violation flag; a fresh notifier edge beats a same-cycle clear.
  always_comb begin
    edge_s = bus.NOTIFIER ^ hist_r;
    if (edge_s) begin
      viol_nxt_s = 1'b1;
    end else if (bus.VIOL_CLR) begin
      viol_nxt_s = 1'b0;
    end else begin
      viol_nxt_s = viol_r;
    end
  end

  // State, data and flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= NORMAL;
      rcnt_r       <= {CNT_W{1'b0}};
      q_r          <= RST_VAL;
      set_active_r <= 1'b0;
      viol_r       <= 1'b0;
      hist_r       <= bus.NOTIFIER;
    end else begin
      state_r      <= state_nxt_s;
      rcnt_r       <= rcnt_nxt_s;
      q_r          <= q_nxt_s;
      set_active_r <= set_zone_s;
      viol_r       <= viol_nxt_s;
      hist_r       <= bus.NOTIFIER;
    end
  end

  assign bus.Q          = q_r;
  assign bus.SET_ACTIVE = set_active_r;
  assign bus.VIOL       = viol_r;

endmodule
